// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_e;

    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one shared combinational-read memory.
// Latency: grant same cycle, response exactly one cycle after the grant.
// Backpressure: a denied requester holds its request; fetch is forced after STARVE_LIMIT denials.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    input  logic [2:0]        d_funct3_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic [2:0]        mem_funct3_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    arb_owner_e last_owner;
    arb_owner_e owner_nxt;

    // Data wins by default; a starved fetch overrides it.
    always_comb begin
        if_gnt_o = 1'b0;
        d_gnt_o  = 1'b0;
        if (!rst) begin
            if (if_req_i && (starve_cnt == LIMIT || !d_req_i)) begin
                if_gnt_o = 1'b1;
            end else if (d_req_i) begin
                d_gnt_o = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_funct3_o   = 3'b000;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (if_gnt_o) begin
            mem_addr_o    = if_addr_i;
            mem_funct3_o  = FUNCT3_LW;
            mem_read_en_o = 1'b1;
        end else if (d_gnt_o) begin
            mem_addr_o     = d_addr_i;
            mem_data_o     = d_wdata_i;
            mem_funct3_o   = d_funct3_i;
            mem_read_en_o  = !d_we_i;
            mem_write_en_o = d_we_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !if_req_i || if_gnt_o) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_NONE;
        end else begin
            last_owner <= owner_nxt;
        end
    end

    always_comb begin
        owner_nxt = OWN_NONE;
        if (if_gnt_o) begin
            owner_nxt = OWN_IF;
        end else if (d_gnt_o) begin
            owner_nxt = OWN_D;
        end
    end

    // Gated by rst so a response in flight when reset arrives never escapes.
    always_comb begin
        if_rvalid_o = (last_owner == OWN_IF) && !rst;
        d_rvalid_o  = (last_owner == OWN_D) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_o <= '0;
            d_rdata_o  <= '0;
        end else if (if_gnt_o) begin
            if_rdata_o <= mem_data_i;
        end else if (d_gnt_o) begin
            d_rdata_o <= d_we_i ? '0 : mem_data_i;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressable little-endian memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [2:0]    d_funct3;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [2:0]    mem_funct3;
    logic          mem_read_en, mem_write_en;

    logic [7:0]    mem_bytes [4096];
    logic [11:0]   ma;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_funct3_i(d_funct3), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_funct3_o(mem_funct3),
        .mem_read_en_o(mem_read_en), .mem_write_en_o(mem_write_en),
        .mem_data_i(mem_rdata)
    );

    assign ma = mem_addr[11:0];

    always_comb begin
        mem_rdata = '0;
        if (mem_read_en) begin
            case (mem_funct3)
                3'b000:  mem_rdata = {{24{mem_bytes[ma][7]}}, mem_bytes[ma]};
                3'b001:  mem_rdata = {{16{mem_bytes[ma+12'd1][7]}}, mem_bytes[ma+12'd1], mem_bytes[ma]};
                3'b100:  mem_rdata = {24'd0, mem_bytes[ma]};
                3'b101:  mem_rdata = {16'd0, mem_bytes[ma+12'd1], mem_bytes[ma]};
                default: mem_rdata = {mem_bytes[ma+12'd3], mem_bytes[ma+12'd2],
                                      mem_bytes[ma+12'd1], mem_bytes[ma]};
            endcase
        end
    end

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem_bytes[ma] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00) mem_bytes[ma+12'd1] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem_bytes[ma+12'd2] <= mem_wdata[23:16];
                mem_bytes[ma+12'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b1; if_addr = '0; d_req = 1'b1; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_funct3 = FUNCT3_LW;

        // Reset: grants and strobes forced low even with both requests up.
        step(); step(); #1;
        check("rst_if_gnt", if_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_strobes", {mem_read_en, mem_write_en}, 0);
        check("rst_rvalid", {if_rvalid, d_rvalid}, 0);
        check("rst_rdata", {if_rdata, d_rdata}, 0);
        check("rst_starve", dut.starve_cnt, 0);
        check("rst_owner", dut.last_owner, OWN_NONE);

        step(); rst = 1'b0; if_req = 1'b0; d_req = 1'b0; #1;

        // Preload the fetch word through the data port.
        step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0000;
        d_wdata = 32'h0050_0113; d_funct3 = FUNCT3_SW; #1;
        check("pre_d_gnt", d_gnt, 1);

        // Fetch alone.
        step(); d_req = 1'b0; d_we = 1'b0; if_req = 1'b1; if_addr = 32'h0100_0000; #1;
        check("f_if_gnt", if_gnt, 1);
        check("f_d_gnt", d_gnt, 0);
        check("f_mem_addr", mem_addr, 32'h0100_0000);
        check("f_strobes", {mem_read_en, mem_write_en}, 2'b10);
        check("f_funct3", mem_funct3, 3'b010);
        check("pre_store_rsp", {d_rvalid, d_rdata}, {1'b1, 32'h0});
        step(); if_req = 1'b0; #1;
        check("f_rvalid", if_rvalid, 1);
        check("f_rdata", if_rdata, 32'h0050_0113);
        step(); #1;
        check("f_rvalid_drop", if_rvalid, 0);
        check("f_rdata_hold", if_rdata, 32'h0050_0113);

        // Contention: four data grants, then a forced fetch grant, repeating.
        for (int k = 0; k < 10; k++) begin
            step(); if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
            d_addr = 32'h0100_0000; d_funct3 = FUNCT3_LW; #1;
            check($sformatf("c_if_gnt%0d", k), if_gnt, (k % 5) == 4);
            check($sformatf("c_d_gnt%0d", k), d_gnt, (k % 5) != 4);
            if (k > 0) begin
                check($sformatf("c_d_rvalid%0d", k), d_rvalid, ((k - 1) % 5) != 4);
                check($sformatf("c_if_rvalid%0d", k), if_rvalid, ((k - 1) % 5) == 4);
            end
            if (k == 4) check("c_starve_sat", dut.starve_cnt, 4);
        end
        step(); if_req = 1'b0; d_req = 1'b0; #1;
        check("c_last_if_rvalid", if_rvalid, 1);

        // Store then byte load from the same word.
        step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0100;
        d_wdata = 32'hDEAD_BEEF; d_funct3 = FUNCT3_SW; #1;
        check("s_d_gnt", d_gnt, 1);
        check("s_strobes", {mem_read_en, mem_write_en}, 2'b01);
        check("s_mem_data", mem_wdata, 32'hDEAD_BEEF);
        step(); d_we = 1'b0; d_addr = 32'h0100_0101; d_funct3 = FUNCT3_LBU; #1;
        check("s_rvalid", d_rvalid, 1);
        check("s_rdata", d_rdata, 0);
        check("l_mem_funct3", mem_funct3, 3'b100);
        check("l_mem_addr", mem_addr, 32'h0100_0101);
        step(); d_req = 1'b0; #1;
        check("l_rvalid", d_rvalid, 1);
        check("l_rdata", d_rdata, 32'h0000_00BE);

        // Reset arriving in the cycle after a data grant.
        step(); if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h0100_0000; d_funct3 = FUNCT3_LW; #1;
        check("r_d_gnt", d_gnt, 1);
        step(); rst = 1'b1; d_req = 1'b0; #1;
        check("r_rvalid_in_rst", d_rvalid, 0);
        check("r_if_gnt_in_rst", if_gnt, 0);
        check("r_starve_before", dut.starve_cnt, 1);
        step(); rst = 1'b0; if_req = 1'b0; #1;
        check("r_rvalid_after", d_rvalid, 0);
        check("r_rdata_after", d_rdata, 0);
        check("r_starve_after", dut.starve_cnt, 0);
        check("r_owner_after", dut.last_owner, OWN_NONE);

        // Idle.
        for (int k = 0; k < 10; k++) begin
            step(); #1;
            check($sformatf("idle_ctl%0d", k),
                  {if_gnt, d_gnt, mem_read_en, mem_write_en, if_rvalid, d_rvalid}, 0);
            check($sformatf("idle_bus%0d", k), {mem_addr, mem_wdata, mem_funct3}, 0);
        end

        // Fetch request dropped after two denials.
        step(); if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; #1;
        check("dr_if_gnt0", if_gnt, 0);
        check("dr_starve0", dut.starve_cnt, 0);
        step(); #1;
        check("dr_if_gnt1", if_gnt, 0);
        check("dr_starve1", dut.starve_cnt, 1);
        step(); if_req = 1'b0; d_req = 1'b0; #1;
        check("dr_if_rvalid0", if_rvalid, 0);
        check("dr_starve2", dut.starve_cnt, 2);
        step(); #1;
        check("dr_if_rvalid1", if_rvalid, 0);
        check("dr_starve_clr", dut.starve_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
